seven_seg_display: RTL and testbench
====================================

# seven_seg_display

- Drives the ALU operands and result onto a 4-digit, common-anode seven-segment display.
- Sits downstream of the operand-entry decoder and the ALU, closing the user-facing loop: buttons set A and B, and this block shows A, B and the result.
- Time-multiplexes the four digits with a refresh counter.
- Snapshots inputs once per full scan so a digit never tears mid-scan.
- Optionally blinks the operand currently being edited.

## Interface

Parameters:
- REFRESH_DIV, 100000: in_clk cycles each digit is held; must be ≥ 2.
- BLINK_DIV, 25000000: in_clk cycles per blink phase; used only with DISPLAY_BLINK_EN.

Ports:
- in_clk  input  1  system clock; the only clock.
- reset_n  input  1  reset, synchronous and active-low.
- A  input  4  operand A.
- B  input  4  operand B.
- result  input  8  ALU result.
- state  input  1  operand selector: 0 = A being edited, 1 = B being edited.
- an  output  4  digit enables, active-low; an[3] is the leftmost digit.
- seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.

## Operation

Digit map:
- Digit 3 = A.
- Digit 2 = B, with dp lit (separates the operands from the result).
- Digit 1 = result[7:4].
- Digit 0 = result[3:0].
- dp is high (off) on every other digit.

Registers:
- Refresh counter: counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
- Digit index: 2 bits.
- Snapshot: {A, B, result, state}.
- All outputs are registered.

Scan:
- When the refresh counter is at REFRESH_DIV-1, the counter clears and the index advances 0→1→2→3→0.
- On the 3→0 advance, the snapshot loads the live inputs.
- Input changes inside a scan are invisible until the next wrap.

Font:
- Full hex font, with b and d shown in lowercase.
- Required patterns: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.

Reset values (reset_n=0 at an edge):
- Counter=0, index=0, snapshot=0, blink phase=0.
- an=1111, seg=1111111, dp=1.
- Reset asserted mid-scan aborts the scan; scanning restarts at index 0.

## Timing

- Output latency: an/seg/dp reflect the index and snapshot one cycle after the index changes.
- First cycle after reset release: the first edge with reset_n=1 drives an=1110 and seg=1000000 (snapshot 0, so the display reads 0).
- Each digit is enabled for exactly REFRESH_DIV consecutive cycles.
- A full scan takes 4·REFRESH_DIV cycles.
- Snapshot timing: the value displayed on digit 3 at index 3 was captured at the start of that scan.
- Input activity never stalls or resets the scan.

## Configuration

DISPLAY_BLINK_EN defined:
- A blink counter runs 0..BLINK_DIV-1 and toggles the blink phase at terminal count; it is independent of the refresh counter.
- While phase=1, the selected operand's digit is blanked: snapshot state=0 blanks digit 3, state=1 blanks digit 2.
- Blanking means that digit's an bit is held at 1 during its slot, with seg=1111111 and dp=1.
- The result digits never blink.
- Reset clears the blink counter and phase.

DISPLAY_BLINK_EN undefined:
- No blink logic; BLINK_DIV is ignored.
- All four digits are driven every scan.

## Test plan

Use REFRESH_DIV=4 and BLINK_DIV=8 in simulation.
- Reset: hold reset_n=0 for 5 cycles → an=1111, seg=1111111, dp=1. Release → first edge gives an=1110, seg=1000000, dp=1.
- Scan order: free-run → an cycles 1110, 1101, 1011, 0111, each for exactly 4 cycles, then repeats.
- Font and map: A=4'hA, B=4'h1, result=8'hF8, allow one wrap →
  - digit 3: seg=0001000;
  - digit 2: seg=1111001 with dp=0;
  - digit 1: seg=0001110;
  - digit 0: seg=0000000;
  - dp=1 on all digits other than digit 2.
- Snapshot: during index 1, change A from 3 to 7 → digit 3 shows 3 for the rest of that scan and 7 from the next scan.
- Blink (macro on, state=1):
  - digit 2's an bit stays 1 during phase=1 slots and asserts during phase=0 slots;
  - digit 3 is unaffected.
  - Macro off: digit 2 asserts in every scan.
- Mid-scan reset: drive reset_n=0 for 1 cycle at index 2 → next edge gives all outputs off. After release, the scan restarts at an=1110 showing 0 on every digit.

Source files
------------

// File: rtl/seven_seg_display.sv
// seven_seg_display: 4-digit common-anode seven-segment driver.
// Shows operand A (digit 3), operand B with decimal point (digit 2) and the
// 8-bit ALU result in hex (digits 1..0). Digits are time-multiplexed by a
// refresh counter. The inputs are snapshotted once per full scan so that a
// scan never mixes old and new values.
// Optional feature macro: DISPLAY_BLINK_EN. When it is defined, the operand
// currently being edited blinks at a rate set by BLINK_DIV.
// All segment/anode/dp signals are active-low. Segment order is {g,f,e,d,c,b,a}.
module seven_seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       in_clk,
  input  logic       reset_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [7:0] result,
  input  logic       state,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // A REFRESH_DIV of 1 is illegal. The width is still kept at 1 or more so
  // the vectors are never empty.
  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Hex font, active-low {g,f,e,d,c,b,a}. The letters b and d are lowercase
  // so they cannot be confused with 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Refresh counter and digit index
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          slot_end;
  logic          scan_end;

  // Input snapshot
  logic [3:0] snap_a_q, snap_a_d;
  logic [3:0] snap_b_q, snap_b_d;
  logic [7:0] snap_res_q, snap_res_d;
  logic       snap_state_q, snap_state_d;

  // Registered display outputs
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] nib;
  logic       blank;

  // Advance the refresh counter. The digit index steps once per slot.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    scan_end = slot_end && (idx_q == 2'd3);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
  end

  // Refresh counter and digit index registers. Reset aborts any scan in progress.
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Capture the live inputs only on the 3->0 wrap, so a scan is always consistent.
  always_comb begin
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
    snap_res_d   = snap_res_q;
    snap_state_d = snap_state_q;
    if (scan_end) begin
      snap_a_d     = A;
      snap_b_d     = B;
      snap_res_d   = result;
      snap_state_d = state;
    end
  end

  // Snapshot registers
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      snap_a_q     <= '0;
      snap_b_q     <= '0;
      snap_res_q   <= '0;
      snap_state_q <= 1'b0;
    end else begin
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
      snap_res_q   <= snap_res_d;
      snap_state_q <= snap_state_d;
    end
  end

`ifdef DISPLAY_BLINK_EN
  // The blink timebase runs freely and independently of the refresh scan.
  localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_END = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Blink counter. The phase toggles at the terminal count.
  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BLINK_END) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Blank the operand being edited during the "off" phase. The result digits never blink.
  always_comb begin
    blank = 1'b0;
    if (phase_q) begin
      blank = snap_state_q ? (idx_q == 2'd2) : (idx_q == 2'd3);
    end
  end
`else
  // Without blinking, the editing selector is carried in the snapshot but is not used.
  logic unused_snap_state;
  assign unused_snap_state = snap_state_q;
  assign blank             = 1'b0;
`endif

  // Select the digit for the current index and decode it. The decimal point
  // separates the operands from the result.
  always_comb begin
    nib  = snap_res_q[3:0];
    an_d = 4'b1110;
    dp_d = 1'b1;
    unique case (idx_q)
      2'd3: begin
        nib  = snap_a_q;
        an_d = 4'b0111;
      end
      2'd2: begin
        nib  = snap_b_q;
        an_d = 4'b1011;
        dp_d = 1'b0;
      end
      2'd1: begin
        nib  = snap_res_q[7:4];
        an_d = 4'b1101;
      end
      default: begin
        nib  = snap_res_q[3:0];
        an_d = 4'b1110;
      end
    endcase
    seg_d = hex_to_seg(nib);
    if (blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // Output registers. The display goes dark while reset is held.
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// Testbench for seven_seg_display with REFRESH_DIV=4 and BLINK_DIV=8.
// Before each clock edge, the expected display word for that edge is pushed
// to a queue. After the edge the word is popped and compared with the DUT.
module tb_seven_seg_display;

  localparam int RDIV = 4;
  localparam int BDIV = 8;
  localparam int SCAN = 4 * RDIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  localparam out_t OUT_OFF = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};

  logic       in_clk;
  logic       reset_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] result;
  logic       state;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seven_seg_display #(
    .REFRESH_DIV(RDIV),
    .BLINK_DIV  (BDIV)
  ) dut (
    .in_clk (in_clk),
    .reset_n(reset_n),
    .A      (A),
    .B      (B),
    .result (result),
    .state  (state),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Reference font, active-low {g,f,e,d,c,b,a}
  logic [6:0] font [16];
  initial begin
    font[0]  = 7'b1000000; font[1]  = 7'b1111001; font[2]  = 7'b0100100; font[3]  = 7'b0110000;
    font[4]  = 7'b0011001; font[5]  = 7'b0010010; font[6]  = 7'b0000010; font[7]  = 7'b1111000;
    font[8]  = 7'b0000000; font[9]  = 7'b0010000; font[10] = 7'b0001000; font[11] = 7'b0000011;
    font[12] = 7'b1000110; font[13] = 7'b0100001; font[14] = 7'b0000110; font[15] = 7'b0001110;
  end

  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state. k counts the edges since reset was released.
  int         k;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [7:0] m_res;
  logic       m_st;

  function automatic out_t model(input int kk, input logic [3:0] sa, input logic [3:0] sb,
                                 input logic [7:0] sr, input logic sst);
    out_t       o;
    int         d;
    logic [3:0] nib;
    logic       ph;
    d     = (kk / RDIV) % 4;
    ph    = ((kk / BDIV) % 2) == 1;
    nib   = (d == 3) ? sa : (d == 2) ? sb : (d == 1) ? sr[7:4] : sr[3:0];
    o.an  = ~(4'b0001 << d);
    o.seg = font[nib];
    o.dp  = (d == 2) ? 1'b0 : 1'b1;
`ifdef DISPLAY_BLINK_EN
    if (ph && ((d == 3 && !sst) || (d == 2 && sst))) o = OUT_OFF;
`else
    if (ph && sst && 1'b0) o = OUT_OFF;
`endif
    return o;
  endfunction

  // One clock edge: predict, advance the model, wait for the edge, then compare.
  task automatic step(input string tag);
    out_t e;
    out_t o;
    if (!reset_n) begin
      exp_q.push_back(OUT_OFF);
      k     = 0;
      m_a   = '0;
      m_b   = '0;
      m_res = '0;
      m_st  = 1'b0;
    end else begin
      exp_q.push_back(model(k, m_a, m_b, m_res, m_st));
      if ((k % SCAN) == SCAN - 1) begin
        m_a   = A;
        m_b   = B;
        m_res = result;
        m_st  = state;
      end
      k++;
    end
    @(posedge in_clk);
    #1;
    o = '{an: an, seg: seg, dp: dp};
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s k=%0d got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
             tag, k, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
    end
  endtask

  initial begin
    k       = 0;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
    m_st    = 1'b0;
    reset_n = 1'b0;
    A       = 4'h5;
    B       = 4'h6;
    result  = 8'h77;
    state   = 1'b0;

    // Reset held for 5 cycles: the display is dark
    for (int i = 0; i < 5; i++) step("reset");

    // Release. The first scan shows the zero snapshot and the second shows A,1,F,8
    A       = 4'hA;
    B       = 4'h1;
    result  = 8'hF8;
    reset_n = 1'b1;
    for (int i = 0; i < 2 * SCAN; i++) step("font_map");

    // Snapshot: A=3 settles over a wrap, then changes to 7 during index 1
    A = 4'h3;
    for (int i = 0; i < SCAN + 4; i++) step("snap_pre");
    while (((k / RDIV) % 4) != 1) step("snap_align");
    step("snap_idx1");
    A = 4'h7;
    for (int i = 0; i < 2 * SCAN + 4; i++) step("snap_post");

    // Operand B selected for editing
    state  = 1'b1;
    B      = 4'hD;
    result = 8'h2C;
    for (int i = 0; i < 3 * SCAN; i++) step("blink_b");

    // Mid-scan reset during index 2, then restart from digit 0 with a zero snapshot
    while ((k % SCAN) != 9) step("mid_align");
    reset_n = 1'b0;
    step("mid_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 2 * SCAN; i++) step("after_reset");

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
